// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the MEM-stage load/store controller.
// Holds access-size codes, the controller FSM state type and the default datapath width.
// Imported by mem_align and mem_ctrl.
package mem_pkg;

   // Default datapath/address width for the RV64 core
   localparam int unsigned XLEN_DEFAULT = 64;

   // funct3[1:0] access-size encodings
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage

// File: rtl/mem_align.sv
// mem_align: byte-lane alignment helpers for the MEM stage.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs every cycle.
module mem_align
   import mem_pkg::*;
#(
   parameter int unsigned XLEN   = XLEN_DEFAULT,
   parameter int unsigned STRB_W = XLEN / 8
) (
   input  logic [1:0]        ex_size,
   input  logic [2:0]        ex_off,
   input  logic [XLEN-1:0]   ex_data,
   output logic              misalign,
   output logic [XLEN-1:0]   lane_data,
   output logic [STRB_W-1:0] lane_strb,
   input  logic [1:0]        ld_size,
   input  logic              ld_unsigned,
   input  logic [2:0]        ld_off,
   input  logic [XLEN-1:0]   ld_raw,
   output logic [XLEN-1:0]   ld_data
);

   logic [STRB_W-1:0] base_strb;
   logic [XLEN-1:0]   ld_shift;
   logic              ext;

   // Misalignment check and store byte-lane placement for the access EX presents
   always_comb begin
      misalign  = 1'b0;
      base_strb = STRB_W'(8'h01);
      case (ex_size)
         SZ_B: begin
            misalign  = 1'b0;
            base_strb = STRB_W'(8'h01);
         end
         SZ_H: begin
            misalign  = ex_off[0];
            base_strb = STRB_W'(8'h03);
         end
         SZ_W: begin
            misalign  = |ex_off[1:0];
            base_strb = STRB_W'(8'h0F);
         end
         default: begin
            misalign  = |ex_off;
            base_strb = STRB_W'(8'hFF);
         end
      endcase
      lane_strb = base_strb << ex_off;
      lane_data = ex_data << {ex_off, 3'b000};
   end

   // Pull the addressed bytes down to bit 0 and sign/zero extend by size
   always_comb begin
      ld_shift = ld_raw >> {ld_off, 3'b000};
      ext      = 1'b0;
      ld_data  = ld_shift;
      case (ld_size)
         SZ_B: begin
            ext     = ~ld_unsigned & ld_shift[7];
            ld_data = {{(XLEN-8){ext}}, ld_shift[7:0]};
         end
         SZ_H: begin
            ext     = ~ld_unsigned & ld_shift[15];
            ld_data = {{(XLEN-16){ext}}, ld_shift[15:0]};
         end
         SZ_W: begin
            ext     = ~ld_unsigned & ld_shift[31];
            ld_data = {{(XLEN-32){ext}}, ld_shift[31:0]};
         end
         default: begin
            ext     = 1'b0;
            ld_data = ld_shift;
         end
      endcase
   end

endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: MEM-stage load/store sequencer driving the data-memory req/gnt/rvalid port.
// Latency: store >= 3 cycles (accept, REQ until gnt, DONE); load >= 4 (adds WAIT until rvalid).
// Backpressure: stall_o holds IF..EX while accepting and in REQ/WAIT; request fields frozen until gnt.
module mem_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned XLEN   = XLEN_DEFAULT,
   parameter int unsigned STRB_W = XLEN / 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_valid_i,
   input  logic              ex_load_i,
   input  logic              ex_store_i,
   input  logic [2:0]        ex_funct3_i,
   input  logic [XLEN-1:0]   ex_addr_i,
   input  logic [XLEN-1:0]   ex_wdata_i,
   output logic              stall_o,
   output logic              dmem_req_o,
   output logic              dmem_we_o,
   output logic [XLEN-1:0]   dmem_addr_o,
   output logic [XLEN-1:0]   dmem_wdata_o,
   output logic [STRB_W-1:0] dmem_wstrb_o,
   input  logic              dmem_gnt_i,
   input  logic              dmem_rvalid_i,
   input  logic [XLEN-1:0]   dmem_rdata_i,
   output logic [XLEN-1:0]   load_data_o,
   output logic              load_valid_o,
   output logic              misalign_o
);

   state_e state, state_nxt;

   logic              lat_load;
   logic [1:0]        lat_size;
   logic              lat_uns;
   logic [2:0]        lat_off;
   logic [XLEN-1:0]   lat_addr;
   logic [XLEN-1:0]   lat_wdata;
   logic [STRB_W-1:0] lat_wstrb;
   logic [XLEN-1:0]   load_data_q;

   logic              is_op;
   logic              accept;
   logic              mis;
   logic [XLEN-1:0]   lane_data;
   logic [STRB_W-1:0] lane_strb;
   logic [XLEN-1:0]   ld_ext;

   mem_align #(
      .XLEN   (XLEN),
      .STRB_W (STRB_W)
   ) u_align (
      .ex_size     (ex_funct3_i[1:0]),
      .ex_off      (ex_addr_i[2:0]),
      .ex_data     (ex_wdata_i),
      .misalign    (mis),
      .lane_data   (lane_data),
      .lane_strb   (lane_strb),
      .ld_size     (lat_size),
      .ld_unsigned (lat_uns),
      .ld_off      (lat_off),
      .ld_raw      (dmem_rdata_i),
      .ld_data     (ld_ext)
   );

   assign is_op  = ex_valid_i & (ex_load_i | ex_store_i);
   assign accept = (state == IDLE) & is_op & ~mis;

   // State register; reset abandons any access in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state plus stall/request/pulse outputs
   always_comb begin
      state_nxt    = state;
      stall_o      = 1'b0;
      dmem_req_o   = 1'b0;
      load_valid_o = 1'b0;
      misalign_o   = 1'b0;
      case (state)
         IDLE: begin
            misalign_o = is_op & mis;
            if (accept) begin
               stall_o   = 1'b1;
               state_nxt = REQ;
            end
         end
         REQ: begin
            stall_o    = 1'b1;
            dmem_req_o = 1'b1;
            if (dmem_gnt_i) begin
               state_nxt = lat_load ? WAIT : DONE;
            end
         end
         WAIT: begin
            stall_o = 1'b1;
            if (dmem_rvalid_i) begin
               state_nxt = DONE;
            end
         end
         default: begin
            // EX still holds the finished op here, so nothing is accepted
            load_valid_o = lat_load;
            state_nxt    = IDLE;
         end
      endcase
   end

   // Capture the access at acceptance; a load wins if both load and store are set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_load  <= 1'b0;
         lat_size  <= SZ_B;
         lat_uns   <= 1'b0;
         lat_off   <= 3'd0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_wstrb <= '0;
      end else if (accept) begin
         lat_load  <= ex_load_i;
         lat_size  <= ex_funct3_i[1:0];
         lat_uns   <= ex_funct3_i[2];
         lat_off   <= ex_addr_i[2:0];
         lat_addr  <= {ex_addr_i[XLEN-1:3], 3'b000};
         lat_wdata <= lane_data;
         lat_wstrb <= lane_strb;
      end
   end

   // Registered load result, updated only when read data returns in WAIT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_data_q <= '0;
      end else if ((state == WAIT) && dmem_rvalid_i) begin
         load_data_q <= ld_ext;
      end
   end

   assign load_data_o  = load_data_q;
   assign dmem_we_o    = dmem_req_o & ~lat_load;
   assign dmem_addr_o  = dmem_req_o ? lat_addr  : '0;
   assign dmem_wdata_o = dmem_req_o ? lat_wdata : '0;
   assign dmem_wstrb_o = dmem_req_o ? lat_wstrb : '0;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed scoreboard bench for the MEM-stage load/store controller.
// Expected requests and load results are queued when an op is issued and
// consumed when the DUT shows a request or a load_valid pulse.
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ex_valid, ex_load, ex_store;
   logic [2:0]  ex_funct3;
   logic [63:0] ex_addr, ex_wdata;
   logic        stall, dmem_req, dmem_we;
   logic [63:0] dmem_addr, dmem_wdata;
   logic [7:0]  dmem_wstrb;
   logic        dmem_gnt, dmem_rvalid;
   logic [63:0] dmem_rdata;
   logic [63:0] load_data;
   logic        load_valid, misalign;

   typedef struct {
      logic [63:0] addr;
      logic        we;
      logic [63:0] wdata;
      logic [7:0]  strb;
   } req_t;

   req_t        exp_req_q[$];
   logic [63:0] exp_load_q[$];

   int checks   = 0;
   int failures = 0;
   int stall_cnt, lv_cnt, mis_cnt, req_cnt;

   mem_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ex_valid_i    (ex_valid),
      .ex_load_i     (ex_load),
      .ex_store_i    (ex_store),
      .ex_funct3_i   (ex_funct3),
      .ex_addr_i     (ex_addr),
      .ex_wdata_i    (ex_wdata),
      .stall_o       (stall),
      .dmem_req_o    (dmem_req),
      .dmem_we_o     (dmem_we),
      .dmem_addr_o   (dmem_addr),
      .dmem_wdata_o  (dmem_wdata),
      .dmem_wstrb_o  (dmem_wstrb),
      .dmem_gnt_i    (dmem_gnt),
      .dmem_rvalid_i (dmem_rvalid),
      .dmem_rdata_i  (dmem_rdata),
      .load_data_o   (load_data),
      .load_valid_o  (load_valid),
      .misalign_o    (misalign)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_counts();
      stall_cnt = 0;
      lv_cnt    = 0;
      mis_cnt   = 0;
      req_cnt   = 0;
   endtask

   // One clock: sample/score at the falling edge, then advance past the rising edge
   task automatic step();
      req_t r;
      @(negedge clk);
      if (stall) stall_cnt++;
      if (misalign) mis_cnt++;
      if (load_valid) begin
         lv_cnt++;
         chk("load_expected", 64'(exp_load_q.size() != 0), 64'd1);
         if (exp_load_q.size() != 0) chk("load_data", load_data, exp_load_q.pop_front());
      end
      if (dmem_req) begin
         req_cnt++;
         chk("req_expected", 64'(exp_req_q.size() != 0), 64'd1);
         if (exp_req_q.size() != 0) begin
            r = exp_req_q[0];
            chk("req_addr", dmem_addr, r.addr);
            chk("req_we", 64'(dmem_we), 64'(r.we));
            if (r.we) begin
               chk("req_wdata", dmem_wdata, r.wdata);
               chk("req_wstrb", 64'(dmem_wstrb), 64'(r.strb));
            end
            if (dmem_gnt) void'(exp_req_q.pop_front());
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Issue one aligned access, answer with gnt after gw wait cycles and rvalid rw cycles after grant
   task automatic do_op(input string name, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] rd,
                        input int gw, input int rw, input logic exp_we, input logic [63:0] exp_wd,
                        input logic [7:0] exp_strb, input logic [63:0] exp_ld, input int exp_stall);
      req_t r;
      exp_req_q.delete();
      exp_load_q.delete();
      clear_counts();
      r.addr = addr & ~64'h7;
      r.we = exp_we;
      r.wdata = exp_wd;
      r.strb = exp_strb;
      exp_req_q.push_back(r);
      if (!exp_we) exp_load_q.push_back(exp_ld);
      ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3;
      ex_addr = addr; ex_wdata = wd; dmem_rdata = rd;
      step();
      ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
      for (int i = 0; i <= gw; i++) begin
         dmem_gnt = (i == gw);
         step();
      end
      dmem_gnt = 1'b0;
      if (!exp_we) begin
         for (int j = 1; j <= rw; j++) begin
            dmem_rvalid = (j == rw);
            step();
         end
         dmem_rvalid = 1'b0;
      end
      step();
      chk({name, "_stall_cycles"}, 64'(stall_cnt), 64'(exp_stall));
      chk({name, "_load_valid_cnt"}, 64'(lv_cnt), exp_we ? 64'd0 : 64'd1);
      chk({name, "_req_cycles"}, 64'(req_cnt), 64'(gw + 1));
      chk({name, "_req_drained"}, 64'(exp_req_q.size()), 64'd0);
      chk({name, "_load_drained"}, 64'(exp_load_q.size()), 64'd0);
      chk({name, "_misalign_cnt"}, 64'(mis_cnt), 64'd0);
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_stall"}, 64'(stall), 64'd0);
      chk({name, "_req"}, 64'(dmem_req), 64'd0);
      chk({name, "_we"}, 64'(dmem_we), 64'd0);
      chk({name, "_addr"}, dmem_addr, 64'd0);
      chk({name, "_wdata"}, dmem_wdata, 64'd0);
      chk({name, "_wstrb"}, 64'(dmem_wstrb), 64'd0);
      chk({name, "_load_data"}, load_data, 64'd0);
      chk({name, "_load_valid"}, 64'(load_valid), 64'd0);
      chk({name, "_misalign"}, 64'(misalign), 64'd0);
   endtask

   initial begin
      req_t r;
      rst_n = 1'b0;
      ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_funct3 = 3'd0;
      ex_addr = '0; ex_wdata = '0;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
      clear_counts();
      repeat (2) @(posedge clk);
      #1;
      chk_all_zero("reset");
      rst_n = 1'b1;
      step();

      // Stores: SD, SH, SW with funct3[2] set (ignored for stores)
      do_op("sd", 1'b0, 1'b1, 3'b011, 64'h1000, 64'h1122334455667788, 64'h0, 0, 0,
            1'b1, 64'h1122334455667788, 8'hFF, 64'h0, 2);
      do_op("sh", 1'b0, 1'b1, 3'b001, 64'h1002, 64'h1234, 64'h0, 0, 0,
            1'b1, 64'h0000_0000_1234_0000, 8'h0C, 64'h0, 2);
      do_op("sw_u", 1'b0, 1'b1, 3'b110, 64'h1004, 64'hDEADBEEF, 64'h0, 0, 0,
            1'b1, 64'hDEAD_BEEF_0000_0000, 8'hF0, 64'h0, 2);

      // Byte loads with sign and zero extension
      do_op("lb", 1'b1, 1'b0, 3'b000, 64'h2003, 64'h0, 64'h0000_0000_8000_0000, 0, 1,
            1'b0, 64'h0, 8'h0, 64'hFFFF_FFFF_FFFF_FF80, 3);
      do_op("lbu", 1'b1, 1'b0, 3'b100, 64'h2003, 64'h0, 64'h0000_0000_8000_0000, 0, 1,
            1'b0, 64'h0, 8'h0, 64'h0000_0000_0000_0080, 3);

      // Store after LBU: load_data must hold the previous load result
      do_op("sb", 1'b0, 1'b1, 3'b000, 64'h1005, 64'hAB, 64'h0, 0, 0,
            1'b1, 64'h0000_AB00_0000_0000, 8'h20, 64'h0, 2);
      chk("load_data_hold", load_data, 64'h0000_0000_0000_0080);

      do_op("lh", 1'b1, 1'b0, 3'b001, 64'h2006, 64'h0, 64'hBEEF_0000_0000_0000, 0, 1,
            1'b0, 64'h0, 8'h0, 64'hFFFF_FFFF_FFFF_BEEF, 3);
      do_op("lwu", 1'b1, 1'b0, 3'b110, 64'h2004, 64'h0, 64'h89AB_CDEF_0000_0000, 0, 1,
            1'b0, 64'h0, 8'h0, 64'h0000_0000_89AB_CDEF, 3);
      do_op("lw", 1'b1, 1'b0, 3'b010, 64'h2004, 64'h0, 64'h89AB_CDEF_0000_0000, 0, 1,
            1'b0, 64'h0, 8'h0, 64'hFFFF_FFFF_89AB_CDEF, 3);

      // Back-pressure: grant held off 5 cycles, rvalid 3 cycles after grant
      do_op("ld_bp", 1'b1, 1'b0, 3'b011, 64'h2800, 64'h0, 64'h0123_4567_89AB_CDEF, 5, 3,
            1'b0, 64'h0, 8'h0, 64'h0123_4567_89AB_CDEF, 10);

      // Misaligned LW: single misalign pulse, no request, no stall
      exp_req_q.delete();
      exp_load_q.delete();
      clear_counts();
      ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_funct3 = 3'b010; ex_addr = 64'h3002;
      step();
      ex_valid = 1'b0; ex_load = 1'b0;
      step();
      chk("mis_pulse_cnt", 64'(mis_cnt), 64'd1);
      chk("mis_stall_cnt", 64'(stall_cnt), 64'd0);
      chk("mis_req_cnt", 64'(req_cnt), 64'd0);

      do_op("ld_after_mis", 1'b1, 1'b0, 3'b011, 64'h3008, 64'h0, 64'hCAFE_F00D_1234_5678, 0, 1,
            1'b0, 64'h0, 8'h0, 64'hCAFE_F00D_1234_5678, 3);

      // Load and store both set: treated as a load
      do_op("ld_and_st", 1'b1, 1'b1, 3'b011, 64'h3010, 64'h5555, 64'h0F0F_0F0F_0F0F_0F0F, 0, 1,
            1'b0, 64'h0, 8'h0, 64'h0F0F_0F0F_0F0F_0F0F, 3);

      // Reset while in WAIT, then a late rvalid must be dropped
      exp_req_q.delete();
      exp_load_q.delete();
      clear_counts();
      r.addr = 64'h4000; r.we = 1'b0; r.wdata = '0; r.strb = '0;
      exp_req_q.push_back(r);
      ex_valid = 1'b1; ex_load = 1'b1; ex_funct3 = 3'b011; ex_addr = 64'h4000;
      dmem_rdata = 64'h7777_6666_5555_4444;
      step();
      ex_valid = 1'b0; ex_load = 1'b0;
      dmem_gnt = 1'b1;
      step();
      dmem_gnt = 1'b0;
      step();
      chk("rst_pre_in_wait_stall", 64'(stall), 64'd1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("rst_mid");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_counts();
      dmem_rvalid = 1'b1;
      step();
      dmem_rvalid = 1'b0;
      step();
      chk("rst_late_lv_cnt", 64'(lv_cnt), 64'd0);
      chk("rst_late_stall_cnt", 64'(stall_cnt), 64'd0);
      chk("rst_late_req_cnt", 64'(req_cnt), 64'd0);
      chk("rst_late_load_data", load_data, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
